// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: core (port 0) has
// priority, loader (port 1) wins in boot mode or after MAX_WAIT consecutive losses.
module dmem_arbiter #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic        i_we0,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_wdata0,
  output logic        o_gnt0,
  output logic        o_rvalid0,
  output logic        o_err0,
  input  logic        i_req1,
  input  logic        i_we1,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata1,
  output logic        o_gnt1,
  output logic        o_rvalid1,
  output logic        o_err1,
  input  logic        i_prio_loader,
  output logic [31:0] o_rdata,
  output logic        o_core_stall,
  output logic        o_mem_we,
  output logic        o_mem_re,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned WAIT_W = 4;

  logic [WAIT_W-1:0] wait_cnt;
  logic              forced;
  logic              gnt0_c;
  logic              gnt1_c;
  logic              xfer;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic              in_range;
  logic              cmd_port;
  logic              cmd_oor;
  logic              cmd_rd;

  // Grant decision; held low during reset so every output reads 0.
  always_comb begin
    forced = (wait_cnt == WAIT_W'(MAX_WAIT));
    gnt1_c = i_rst_n & i_req1 & (~i_req0 | i_prio_loader | forced);
    gnt0_c = i_rst_n & i_req0 & ~gnt1_c;
    xfer   = gnt0_c | gnt1_c;
    sel_we    = gnt1_c ? i_we1    : i_we0;
    sel_addr  = gnt1_c ? i_addr1  : i_addr0;
    sel_wdata = gnt1_c ? i_wdata1 : i_wdata0;
    in_range  = (sel_addr < 32'(DEPTH));
  end

  assign o_gnt0       = gnt0_c;
  assign o_gnt1       = gnt1_c;
  assign o_core_stall = i_rst_n & i_req0 & ~gnt0_c;

  // Consecutive losses of a pending loader request, saturating at MAX_WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt <= '0;
    end else if (i_req1 & gnt0_c) begin
      if (!forced) wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Command register (access cycle) followed by the response stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_we    <= 1'b0;
      o_mem_re    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      cmd_port    <= 1'b0;
      cmd_oor     <= 1'b0;
      cmd_rd      <= 1'b0;
      o_rvalid0   <= 1'b0;
      o_rvalid1   <= 1'b0;
      o_err0      <= 1'b0;
      o_err1      <= 1'b0;
      o_rdata     <= '0;
    end else begin
      o_mem_we <= xfer & sel_we & in_range;
      o_mem_re <= xfer & ~sel_we & in_range;
      if (xfer) begin
        o_mem_addr  <= sel_addr;
        o_mem_wdata <= sel_wdata;
        cmd_port    <= gnt1_c;
      end
      cmd_oor <= xfer & ~in_range;
      cmd_rd  <= xfer & ~sel_we;

      o_rvalid0 <= o_mem_re & ~cmd_port;
      o_rvalid1 <= o_mem_re & cmd_port;
      o_err0    <= cmd_oor & ~cmd_port;
      o_err1    <= cmd_oor & cmd_port;
      if (o_mem_re) begin
        o_rdata <= i_mem_rdata;
      end else if (cmd_oor & cmd_rd) begin
        o_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand sequences
// for reset/back-to-back traffic, and random traffic against a behavioural model.
module tb_dmem_arbiter;

  localparam int unsigned DEPTH    = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic        clk, rst_n;
  logic        req0, we0, req1, we1, prio;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, stall;
  logic        mem_we, mem_re;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_gnt0(gnt0), .o_rvalid0(rvalid0), .o_err0(err0),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_gnt1(gnt1), .o_rvalid1(rvalid1), .o_err1(err1),
    .i_prio_loader(prio), .o_rdata(rdata), .o_core_stall(stall),
    .o_mem_we(mem_we), .o_mem_re(mem_re), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write commits on the falling edge.
  logic [31:0] mem [DEPTH];
  always @(negedge clk)
    if (mem_we && mem_addr < DEPTH) mem[mem_addr[4:0]] <= mem_wdata;
  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[4:0]] : 32'h0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int          losses;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic        s_rv0, s_rv1, s_er0, s_er1, s_rd_upd;
  logic [31:0] s_rd_val;

  task automatic model_reset();
    losses = 0;
    e_addr = 0; e_wdata = 0; e_rdata = 0;
    s_rv0 = 0; s_rv1 = 0; s_er0 = 0; s_er1 = 0; s_rd_upd = 0; s_rd_val = 0;
  endtask

  // One clock of traffic: drive, check grants, take the edge, check outputs.
  task automatic step(input logic r0, w0, input logic [31:0] a0, d0,
                      input logic r1, w1, input logic [31:0] a1, d1, input logic pr,
                      input logic use_eg, input logic [1:0] eg,
                      input logic use_rd, input logic [31:0] erd,
                      output logic g0, output logic g1);
    logic ex_g0, ex_g1, has, port, we, inr;
    logic [31:0] a, d;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; prio = pr;
    ex_g1 = r1 && (!r0 || pr || losses >= int'(MAX_WAIT));
    ex_g0 = r0 && !ex_g1;
    #1;
    chk("gnt0", 32'(gnt0), 32'(ex_g0));
    chk("gnt1", 32'(gnt1), 32'(ex_g1));
    chk("core_stall", 32'(stall), 32'(r0 && !ex_g0));
    if (use_eg) chk("table_gnt", 32'({gnt1, gnt0}), 32'(eg));
    g0 = ex_g0; g1 = ex_g1;
    has = ex_g0 || ex_g1; port = ex_g1;
    we = port ? w1 : w0; a = port ? a1 : a0; d = port ? d1 : d0;
    losses = (r1 && ex_g0) ? losses + 1 : 0;
    @(posedge clk); #1;
    // Response stage reflects the previous cycle's transfer.
    if (s_rd_upd) e_rdata = s_rd_val;
    chk("rvalid0", 32'(rvalid0), 32'(s_rv0));
    chk("rvalid1", 32'(rvalid1), 32'(s_rv1));
    chk("err0", 32'(err0), 32'(s_er0));
    chk("err1", 32'(err1), 32'(s_er1));
    chk("rdata", rdata, e_rdata);
    if (use_rd) chk("table_rdata", rdata, erd);
    // Access stage reflects this cycle's transfer.
    inr = (a < DEPTH);
    if (has) begin e_addr = a; e_wdata = d; end
    chk("mem_we", 32'(mem_we), 32'(has && we && inr));
    chk("mem_re", 32'(mem_re), 32'(has && !we && inr));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    s_rv0 = has && !we && inr && !port;
    s_rv1 = has && !we && inr && port;
    s_er0 = has && !inr && !port;
    s_er1 = has && !inr && port;
    s_rd_upd = has && !we;
    s_rd_val = inr ? m_mem[a[4:0]] : 32'h0;
    if (has && we && inr) m_mem[a[4:0]] = d;
  endtask

  typedef struct {
    logic r0, w0; logic [31:0] a0, d0;
    logic r1, w1; logic [31:0] a1, d1;
    logic pr; logic [1:0] eg; logic crd; logic [31:0] erd;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic r0, w0, input logic [31:0] a0, d0,
                              input logic r1, w1, input logic [31:0] a1, d1,
                              input logic pr, input logic [1:0] eg,
                              input logic crd, input logic [31:0] erd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.pr = pr; v.eg = eg; v.crd = crd; v.erd = erd;
    return v;
  endfunction

  typedef struct { logic v, we; logic [31:0] a, d; } pend_t;

  initial begin
    logic g0, g1;
    logic [31:0] old5;
    pend_t p0, p1;

    // Directed table: write/read, round-robin starvation, boot priority, out of range
    vecs.push_back(mk(1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 3, 0,            0, 0, 0, 0, 0, 2'b01, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0, 0, 0, 2'b00, 1, 32'hDEADBEEF));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, 1, 10, 32'(i), 1, 1, 20, 32'(100 + i), 0,
                        (i % 5 == 4) ? 2'b10 : 2'b01, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 1, 11, 32'(i), 1, 1, 21, 32'(200 + i), 1, 2'b10, 0, 0));
    vecs.push_back(mk(1, 1, 11, 32'h77, 0, 0, 0, 0, 1, 2'b01, 0, 0));
    vecs.push_back(mk(1, 0, 32, 0,      0, 0, 0, 0, 0, 2'b01, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0, 0, 0, 0, 2'b00, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0,       0, 0, 0, 0, 0, 2'b00, 0, 0));

    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = 32'hA5A5_0000 | 32'(i);
      m_mem[i] = 32'hA5A5_0000 | 32'(i);
    end
    model_reset();
    rst_n = 1'b0; prio = 0;
    req0 = 1; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    #12;
    chk("reset_gnt0", 32'(gnt0), 0);
    chk("reset_stall", 32'(stall), 0);
    chk("reset_mem_re", 32'(mem_re), 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_rvalid0", 32'(rvalid0), 0);
    req0 = 0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      step(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
           vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1, vecs[i].pr,
           1'b1, vecs[i].eg, vecs[i].crd, vecs[i].erd, g0, g1);

    // Back-to-back core writes then reads, one transfer per cycle
    for (int i = 0; i < int'(DEPTH); i++)
      step(1, 1, 32'(i), 32'h5000_0000 + 32'(i), 0, 0, 0, 0, 0, 1, 2'b01, 0, 0, g0, g1);
    for (int i = 0; i < int'(DEPTH); i++)
      step(1, 0, 32'(i), 0, 0, 0, 0, 0, 0, 1, 2'b01, i > 0, 32'h5000_0000 + 32'(i - 1), g0, g1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 1, 32'h5000_001F, g0, g1);

    // Reset during the access cycle of a write to addr 5
    old5 = m_mem[5];
    req0 = 1; we0 = 1; addr0 = 5; wdata0 = 32'hC0FFEE00;
    #1;
    chk("rst_seq_gnt0", 32'(gnt0), 1);
    @(posedge clk); #1;
    chk("rst_seq_mem_we_before", 32'(mem_we), 1);
    chk("rst_seq_mem_addr_before", mem_addr, 5);
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    #1;
    chk("rst_seq_mem_we", 32'(mem_we), 0);
    chk("rst_seq_mem_addr", mem_addr, 0);
    chk("rst_seq_mem_wdata", mem_wdata, 0);
    chk("rst_seq_rdata", rdata, 0);
    @(negedge clk); #1;
    chk("rst_seq_mem5_kept", mem[5], old5);
    model_reset();
    rst_n = 1'b1;
    step(1, 0, 5, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0, g0, g1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 1, old5, g0, g1);

    // Random traffic; requests are held until granted, occasionally withdrawn
    p0 = '{v: 0, we: 0, a: 0, d: 0};
    p1 = '{v: 0, we: 0, a: 0, d: 0};
    for (int n = 0; n < 400; n++) begin
      logic rp;
      if (!p0.v) begin
        if ($urandom_range(0, 3) != 0) begin
          p0.v = 1; p0.we = 1'($urandom_range(0, 1));
          p0.a = ($urandom_range(0, 39) > 35) ? $urandom : 32'($urandom_range(0, 35));
          p0.d = $urandom;
        end
      end else if ($urandom_range(0, 15) == 0) p0.v = 0;
      if (!p1.v) begin
        if ($urandom_range(0, 1) != 0) begin
          p1.v = 1; p1.we = 1'($urandom_range(0, 1));
          p1.a = 32'($urandom_range(0, 35)); p1.d = $urandom;
        end
      end else if ($urandom_range(0, 15) == 0) p1.v = 0;
      rp = ($urandom_range(0, 9) == 0);
      step(p0.v, p0.we, p0.a, p0.d, p1.v, p1.we, p1.a, p1.d, rp, 0, 2'b00, 0, 0, g0, g1);
      if (g0) p0.v = 0;
      if (g1) p1.v = 0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, g0, g1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
